// File: rtl/vga_display_ctrl.sv
// VGA display timing and output stage.
// Derives a pixel-clock enable from the system clock, runs the horizontal and
// vertical counters, and drives the sync and RGB pins. Sync and blanking are
// delayed by PIX_LAT pixel periods so that they line up with the pixel value
// returned by the generators.
module vga_display_ctrl #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int PIX_LAT   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] pixel_in,
    output logic [9:0]  h_cnt,
    output logic [9:0]  v_cnt,
    output logic        valid,
    output logic        pclk_en,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             h_wrap, v_wrap;
    logic             hs_raw, vs_raw;

    // Pixel enable is a decode of the divider register, so it is glitch-free
    // and exactly one clk wide.
    assign pclk_en     = (div_q == DIV_W'(CLK_DIV - 1));
    assign h_wrap      = (h_q == 10'(H_TOTAL - 1));
    assign v_wrap      = (v_q == 10'(V_TOTAL - 1));
    assign frame_start = pclk_en & h_wrap & v_wrap;

    assign h_cnt = h_q;
    assign v_cnt = v_q;
    assign valid = (h_q < 10'(H_VISIBLE)) && (v_q < 10'(V_VISIBLE));

    assign hs_raw = !((h_q >= 10'(HS_START)) && (h_q < 10'(HS_END)));
    assign vs_raw = !((v_q >= 10'(VS_START)) && (v_q < 10'(VS_END)));

    // Next-state for divider and counters; h and v wrap together in one edge.
    always_comb begin
        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;
        if (pclk_en) begin
            div_d = '0;
            if (h_wrap) begin
                h_d = 10'd0;
                v_d = v_wrap ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    // Divider and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            h_q   <= 10'd0;
            v_q   <= 10'd0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    // Delay line for {hs, vs, valid}. tap[0] is the undelayed value and
    // tap[PIX_LAT] feeds the output register; with PIX_LAT=0 no stages exist.
    logic [PIX_LAT:0][2:0] tap;
    logic [2:0]            dly;

    assign tap[0] = {hs_raw, vs_raw, valid};

    genvar gi;
    generate
        for (gi = 0; gi < PIX_LAT; gi++) begin : g_dly
            logic [2:0] stage_q;
            // One pixel-period stage; resets to inactive syncs and blanked video.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_q <= 3'b110;
                end else if (pclk_en) begin
                    stage_q <= tap[gi];
                end
            end
            assign tap[gi+1] = stage_q;
        end
    endgenerate

    assign dly = tap[PIX_LAT];

    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic [11:0] rgb_q, rgb_d;

    // Output pins load once per pixel; RGB is forced to black while blanked.
    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        rgb_d   = rgb_q;
        if (pclk_en) begin
            hsync_d = dly[2];
            vsync_d = dly[1];
            rgb_d   = dly[0] ? pixel_in : 12'h000;
        end
    end

    // Output register stage driving the VGA pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= 12'h000;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
        end
    end

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign vga_r = rgb_q[11:8];
    assign vga_g = rgb_q[7:4];
    assign vga_b = rgb_q[3:0];

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Bench for vga_display_ctrl: one instance at the standard 640x480 timing with
// PIX_LAT=0, one with a shrunken raster and PIX_LAT=2 so whole frames fit in
// a short run. A reference model of the counters feeds a scoreboard queue of
// expected pin values, popped as each pixel reaches the output register.
module tb_vga_display_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [11:0] pix0, pix1;
    logic [9:0]  h0, v0, h1, v1;
    logic        valid0, pe0, fs0, hs0, vs0;
    logic        valid1, pe1, fs1, hs1, vs1;
    logic [3:0]  r0, g0, b0, r1, g1, b1;

    vga_display_ctrl #(.CLK_DIV(4), .PIX_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .pixel_in(pix0),
        .h_cnt(h0), .v_cnt(v0), .valid(valid0), .pclk_en(pe0),
        .frame_start(fs0), .hsync(hs0), .vsync(vs0),
        .vga_r(r0), .vga_g(g0), .vga_b(b0)
    );

    vga_display_ctrl #(
        .CLK_DIV(3),
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .PIX_LAT(2)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .pixel_in(pix1),
        .h_cnt(h1), .v_cnt(v1), .valid(valid1), .pclk_en(pe1),
        .frame_start(fs1), .hsync(hs1), .vsync(vs1),
        .vga_r(r1), .vga_g(g1), .vga_b(b1)
    );

    // Timing parameters of both instances, as the model sees them.
    int cd[2], hvis[2], hfr[2], hsy[2], htot[2];
    int vvis[2], vfr[2], vsy[2], vtot[2], lat[2];

    // Reference model state.
    int          m_div[2], m_h[2], m_v[2];
    bit          m_pe[2];
    logic [13:0] m_out[2];
    logic [13:0] exp_q0[$], exp_q1[$];
    logic [11:0] pix_q0[$], pix_q1[$];
    bit          in_rst;
    int          pix_mode;
    int          cyc;

    int n_vec = 0;
    int n_err = 0;

    // Statistics for the targeted timing checks.
    bit hs0_prev, hs0_active; int hs0_len, hs0_lines;
    bit vs1_prev, vs1_active; int vs1_len, vs1_lines;
    bit fs1_prev_ok; int fs1_cyc, fs1_seen, model_fs1;
    int fff_state, fff_rem, fff_cnt;
    int pe0_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [11:0] pix_fn(input int h, input int v);
        case (pix_mode)
            1:       return 12'hFFF;
            0:       return 12'(h);
            default: return 12'((v % 64) * 64 + (h % 64));
        endcase
    endfunction

    // Expected {hsync, vsync, rgb} for the given counts and returned pixel.
    function automatic logic [13:0] raw_out(input int d, input int h, input int v, input logic [11:0] p);
        logic hs, vs, vld;
        hs  = !((h >= hvis[d] + hfr[d]) && (h < hvis[d] + hfr[d] + hsy[d]));
        vs  = !((v >= vvis[d] + vfr[d]) && (v < vvis[d] + vfr[d] + vsy[d]));
        vld = (h < hvis[d]) && (v < vvis[d]);
        return {hs, vs, vld ? p : 12'h000};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_div[d] = 0; m_h[d] = 0; m_v[d] = 0; m_pe[d] = 1'b0;
            m_out[d] = 14'h3000;
        end
        exp_q0.delete(); exp_q1.delete(); pix_q0.delete(); pix_q1.delete();
        for (int i = 0; i < lat[0]; i++) begin exp_q0.push_back(14'h3000); pix_q0.push_back(12'h000); end
        for (int i = 0; i < lat[1]; i++) begin exp_q1.push_back(14'h3000); pix_q1.push_back(12'h000); end
        hs0_prev = 1'b1; hs0_active = 1'b0;
        vs1_prev = 1'b1; vs1_active = 1'b0;
        fs1_prev_ok = 1'b0;
    endtask

    // Drive the pixel for the coming edge and push the expected pin values.
    task automatic pre_edge();
        logic [11:0] p;
        for (int d = 0; d < 2; d++) begin
            m_pe[d] = !in_rst && (m_div[d] == cd[d] - 1);
            if (m_pe[d]) begin
                p = pix_fn(m_h[d], m_v[d]);
                if (d == 0) begin
                    pix_q0.push_back(p); pix0 = pix_q0.pop_front();
                    exp_q0.push_back(raw_out(d, m_h[d], m_v[d], p));
                end else begin
                    pix_q1.push_back(p); pix1 = pix_q1.pop_front();
                    exp_q1.push_back(raw_out(d, m_h[d], m_v[d], p));
                end
            end
        end
    endtask

    task automatic post_edge();
        for (int d = 0; d < 2; d++) begin
            if (!in_rst) begin
                if (m_pe[d]) begin
                    m_out[d] = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    m_div[d] = 0;
                    if (m_h[d] == htot[d] - 1) begin
                        m_h[d] = 0;
                        m_v[d] = (m_v[d] == vtot[d] - 1) ? 0 : m_v[d] + 1;
                    end else begin
                        m_h[d] = m_h[d] + 1;
                    end
                end else begin
                    m_div[d] = m_div[d] + 1;
                end
            end
        end
    endtask

    task automatic compare();
        logic exp_pe, exp_fs, exp_vld;
        for (int d = 0; d < 2; d++) begin
            exp_pe  = !in_rst && (m_div[d] == cd[d] - 1);
            exp_fs  = exp_pe && (m_h[d] == htot[d] - 1) && (m_v[d] == vtot[d] - 1);
            exp_vld = (m_h[d] < hvis[d]) && (m_v[d] < vvis[d]);
            if (d == 1 && exp_fs) model_fs1++;
            if (d == 0) begin
                check_eq("ctr0", {h0, v0, valid0, pe0, fs0},
                         {10'(m_h[d]), 10'(m_v[d]), exp_vld, exp_pe, exp_fs});
                check_eq("out0", {hs0, vs0, r0, g0, b0}, m_out[d]);
            end else begin
                check_eq("ctr1", {h1, v1, valid1, pe1, fs1},
                         {10'(m_h[d]), 10'(m_v[d]), exp_vld, exp_pe, exp_fs});
                check_eq("out1", {hs1, vs1, r1, g1, b1}, m_out[d]);
            end
        end
    endtask

    task automatic stats();
        if (m_pe[0]) begin
            if (hs0_active) begin
                if (!hs0) hs0_len++;
                else begin
                    check_eq("hs0_width", hs0_len, hsy[0]);
                    hs0_active = 1'b0; hs0_lines++;
                end
            end else if (!hs0 && hs0_prev) begin
                check_eq("hs0_fall_h", h0, hvis[0] + hfr[0] + 1);
                hs0_active = 1'b1; hs0_len = 1;
            end
            hs0_prev = hs0;
        end
        if (m_pe[1]) begin
            if (vs1_active) begin
                if (!vs1) vs1_len++;
                else begin
                    check_eq("vs1_width", vs1_len, vsy[1] * htot[1]);
                    vs1_active = 1'b0; vs1_lines++;
                end
            end else if (!vs1 && vs1_prev) begin
                check_eq("vs1_fall_hv", {h1, v1}, {10'(lat[1] + 1), 10'(vvis[1] + vfr[1])});
                vs1_active = 1'b1; vs1_len = 1;
            end
            vs1_prev = vs1;
        end
        if (fff_state == 1 && m_pe[1]) begin
            if ({r1, g1, b1} == 12'hFFF) fff_cnt++;
            fff_rem--;
            if (fff_rem == 0) begin
                check_eq("fff_count", fff_cnt, hvis[1] * vvis[1]);
                fff_state = 2;
            end
        end
        if (fs1) begin
            fs1_seen++;
            if (fs1_prev_ok) check_eq("fs1_gap", cyc - fs1_cyc, htot[1] * vtot[1] * cd[1]);
            fs1_prev_ok = 1'b1;
            fs1_cyc     = cyc;
            if (fff_state == 0 && pix_mode == 1) begin
                fff_state = 1; fff_rem = htot[1] * vtot[1]; fff_cnt = 0;
            end
        end
    endtask

    task automatic do_cycle();
        pre_edge();
        @(posedge clk);
        #1;
        post_edge();
        compare();
        stats();
        cyc++;
    endtask

    initial begin
        cd   = '{4, 3};     lat  = '{0, 2};
        hvis = '{640, 16};  hfr  = '{16, 4};  hsy = '{96, 6};
        htot = '{800, 30};
        vvis = '{480, 10};  vfr  = '{10, 2};  vsy = '{2, 2};
        vtot = '{525, 17};
        cyc = 0; pix_mode = 1; pix0 = 12'h000; pix1 = 12'h000;
        hs0_lines = 0; vs1_lines = 0; fs1_seen = 0; model_fs1 = 0;
        fff_state = 0; pe0_cnt = 0;
        rst_n = 1'b0; in_rst = 1'b1;
        model_reset();
        repeat (3) do_cycle();

        rst_n = 1'b1; in_rst = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            do_cycle();
            if (pe0) pe0_cnt++;
        end
        check_eq("cadence_pe", pe0_cnt, 250);
        check_eq("cadence_h", h0, 250);

        for (int i = 1000; i < 7000; i++) begin
            if (i == 3500) pix_mode = 0;
            if (i == 5500) pix_mode = 2;
            do_cycle();
        end

        // Asynchronous reset between clock edges, mid-line and mid-frame.
        #2;
        rst_n = 1'b0; in_rst = 1'b1;
        model_reset();
        #1;
        compare();
        repeat (3) do_cycle();
        rst_n = 1'b1; in_rst = 1'b0;
        repeat (4) do_cycle();
        check_eq("rel_h0", h0, 1);
        repeat (60) do_cycle();

        check_eq("fs1_count", fs1_seen, model_fs1);
        check_eq("fff_done", fff_state, 2);
        check_eq("hs0_lines", hs0_lines, 2);
        check_eq("vs1_lines", vs1_lines, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
